// File: rtl/delay_timer_pkg.sv
// Shared types and constants for the delay timer harness.
// Holds the FSM state encoding, the default countdown width and the
// "no load" value used for start decoding and delayer load gating.
package delay_timer_pkg;

    // Default width of the load value and the countdown.
    localparam int WIDTH = 12;

    // A load value of zero means "nothing to load" for the delayer and
    // selects the zero-delay path in the control FSM.
    localparam logic [WIDTH-1:0] ZERO_LOAD = '0;

    // Two-bit state encoding; the fourth code is illegal and is steered
    // back to IDLE by the FSM default branch.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/delay_timer_harness_countdown.sv
// Countdown delayer (module delay_countdown).
// A nonzero load value restarts the count; otherwise the count decrements
// once per cycle and saturates at zero. done pulses for one cycle in the
// first cycle the count reads zero after counting down from one.
module delay_countdown #(
    parameter int WIDTH = delay_timer_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load,
    output logic             done,
    output logic             inactive,
    output logic [WIDTH-1:0] countdown
);
    import delay_timer_pkg::*;

    localparam logic [WIDTH-1:0] NO_LOAD = WIDTH'(ZERO_LOAD);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_reg;
    logic             done_reg;

    // Load, decrement with saturation at zero, and flag the 1 -> 0 step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (load != NO_LOAD) begin
                count_reg <= load;
            end else if (count_reg != NO_LOAD) begin
                count_reg <= count_reg - ONE;
                if (count_reg == ONE) begin
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign countdown = count_reg;
    assign done      = done_reg;
    assign inactive  = (count_reg == NO_LOAD);

endmodule

// File: rtl/delay_timer_harness.sv
// Programmable delay harness: start decode, control FSM and an optional
// self-checker around a countdown delayer.
// Optional feature macro: DELAY_HARNESS_ASSERT_EN adds a shadow timer and
// immediate assertions; without it the ports and behaviour are identical.
module delay_timer_harness #(
    parameter int WIDTH = delay_timer_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ui__load,
    input  logic             ui__tb_fanout_flags__trigger,
    input  logic             _ui__tb_fanin_flags__in_start,
    input  logic             _ui__tb_fanin_flags__in_done,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] remaining
);
    import delay_timer_pkg::*;

    localparam logic [WIDTH-1:0] NO_LOAD = WIDTH'(ZERO_LOAD);

    state_t           state_reg;
    logic             done_reg;
    logic             busy_reg;

    logic             load_nonzero;
    logic             start;
    logic             take_start;
    logic [WIDTH-1:0] dly_load;
    logic             dly_done;
    logic             dly_inactive;
    logic [WIDTH-1:0] dly_count;

    // Any of the three request sources starts a delay, but only from IDLE.
    assign load_nonzero = (ui__load != NO_LOAD);
    assign start        = ui__tb_fanout_flags__trigger
                        | _ui__tb_fanin_flags__in_start
                        | load_nonzero;
    assign take_start   = (state_reg == IDLE) && start;

    // The delayer only sees a load value on the accepted start edge, so
    // loads presented during RUN or DONE never disturb the count.
    assign dly_load = take_start ? ui__load : NO_LOAD;

    delay_countdown #(
        .WIDTH (WIDTH)
    ) delayer (
        .clk       (clk),
        .rst       (rst),
        .load      (dly_load),
        .done      (dly_done),
        .inactive  (dly_inactive),
        .countdown (dly_count)
    );

    // Control FSM with registered done/busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // in_done is meaningless here; a start always wins.
                    if (start) begin
                        busy_reg <= 1'b1;
                        if (load_nonzero) begin
                            state_reg <= RUN;
                            done_reg  <= 1'b0;
                        end else begin
                            // Zero delay: skip RUN and finish immediately.
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // The delayer pulse and the zero count coincide; the
                    // zero count alone also guarantees RUN can never stall.
                    if (dly_done || dly_inactive) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    // Acknowledge is honoured even on the DONE entry cycle.
                    if (_ui__tb_fanin_flags__in_done) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign done      = done_reg;
    assign busy      = busy_reg;
    assign remaining = dly_count;

`ifdef DELAY_HARNESS_ASSERT_EN
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] load_reg;
    logic [WIDTH-1:0] shadow_reg;
    logic [WIDTH-1:0] prev_count_reg;
    logic [WIDTH:0]   elapsed_reg;
    logic             timer_ought_to_finish;
    logic             prev_done_reg;
    logic             prev_run_reg;

    // Shadow timer running independently of the delayer, plus history
    // registers used by the checks below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_reg              <= '0;
            shadow_reg            <= '0;
            prev_count_reg        <= '0;
            elapsed_reg           <= '0;
            timer_ought_to_finish <= 1'b0;
            prev_done_reg         <= 1'b0;
            prev_run_reg          <= 1'b0;
        end else begin
            timer_ought_to_finish <= 1'b0;
            if (take_start) begin
                load_reg    <= ui__load;
                shadow_reg  <= ui__load;
                elapsed_reg <= '0;
            end else begin
                if (shadow_reg != NO_LOAD) begin
                    shadow_reg <= shadow_reg - ONE;
                    if (shadow_reg == ONE) begin
                        timer_ought_to_finish <= 1'b1;
                    end
                end
                if (elapsed_reg != '1) begin
                    elapsed_reg <= elapsed_reg + (WIDTH+1)'(1);
                end
            end
            prev_count_reg <= dly_count;
            prev_done_reg  <= done_reg;
            prev_run_reg   <= (state_reg == RUN);
        end
    end

    // Immediate checks sampled on each rising edge outside reset.
    always @(posedge clk) begin
        if (!rst) begin
            a_state_legal: assert (state_reg != state_t'(2'd3));
            a_shadow_matches_delayer: assert (timer_ought_to_finish == dly_done);
            if (state_reg == RUN && dly_inactive) begin
                a_finish_expected: assert (timer_ought_to_finish);
            end
            if (state_reg == RUN && prev_run_reg) begin
                a_count_monotonic: assert (dly_count <= prev_count_reg);
            end
            if (done_reg && !prev_done_reg && load_reg != NO_LOAD) begin
                a_done_latency: assert (elapsed_reg == {1'b0, load_reg} + (WIDTH+1)'(1));
            end
        end
    end
`endif

endmodule

// File: tb/tb_delay_timer_harness.sv
// Scoreboard bench for delay_timer_harness: each scenario pushes the
// expected {done, busy, remaining} for every upcoming edge, then pops and
// compares one entry 1 time unit after each rising edge.
module tb_delay_timer_harness;

    localparam int W = 12;

    typedef struct packed {
        logic         done;
        logic         busy;
        logic [W-1:0] rem;
    } obs_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] load = '0;
    logic         trigger = 1'b0;
    logic         in_start = 1'b0;
    logic         in_done = 1'b0;
    logic         done;
    logic         busy;
    logic [W-1:0] remaining;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    delay_timer_harness #(.WIDTH(W)) dut (
        .clk                           (clk),
        .rst                           (rst),
        .ui__load                      (load),
        .ui__tb_fanout_flags__trigger  (trigger),
        ._ui__tb_fanin_flags__in_start (in_start),
        ._ui__tb_fanin_flags__in_done  (in_done),
        .done                          (done),
        .busy                          (busy),
        .remaining                     (remaining)
    );

    function automatic obs_t mk(input logic d, input logic b, input int r);
        obs_t o;
        o.done = d;
        o.busy = b;
        o.rem  = W'(r);
        return o;
    endfunction

    // A delay of l cycles: remaining l..0 on edges n..n+l, done on n+l+1.
    function automatic void push_run(input int l);
        for (int k = 0; k <= l; k++) exp_q.push_back(mk(1'b0, 1'b1, l - k));
        exp_q.push_back(mk(1'b1, 1'b1, 0));
    endfunction

    task automatic test_reset();
        obs_t e, a;
        rst = 1'b1;
        #1;
        e = mk(1'b0, 1'b0, 0);
        a = '{done: done, busy: busy, rem: remaining};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL reset_async: got %b/%b/%0d want %b/%b/%0d", a.done, a.busy, a.rem, e.done, e.busy, e.rem);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) exp_q.push_back(mk(1'b0, 1'b0, 0));
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            a = '{done: done, busy: busy, rem: remaining};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL reset_idle c%0d: got %b/%b/%0d want %b/%b/%0d", c, a.done, a.busy, a.rem, e.done, e.busy, e.rem);
            end
        end
        $display("txn reset: idle for 10 cycles after reset release");
    endtask

    task automatic test_load_one();
        obs_t e, a;
        load = W'(1);
        push_run(1);
        exp_q.push_back(mk(1'b0, 1'b0, 0));
        exp_q.push_back(mk(1'b0, 1'b0, 0));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            a = '{done: done, busy: busy, rem: remaining};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL load_one c%0d: got %b/%b/%0d want %b/%b/%0d", c, a.done, a.busy, a.rem, e.done, e.busy, e.rem);
            end
            if (c == 0) load = '0;
            if (c == 2) in_done = 1'b1;
            if (c == 3) in_done = 1'b0;
        end
        $display("txn load_one: L=1 done two edges after load");
    endtask

    task automatic test_auto_start();
        obs_t e, a;
        int lens[2] = '{16, 4095};
        foreach (lens[i]) begin
            int l = lens[i];
            load = W'(l);
            push_run(l);
            exp_q.push_back(mk(1'b0, 1'b0, 0));
            for (int c = 0; c <= l + 2; c++) begin
                @(posedge clk); #1;
                e = exp_q.pop_front();
                a = '{done: done, busy: busy, rem: remaining};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL auto_start L=%0d c%0d: got %b/%b/%0d want %b/%b/%0d", l, c, a.done, a.busy, a.rem, e.done, e.busy, e.rem);
                end
                if (c == 0) load = '0;
                if (c == l + 1) in_done = 1'b1;
                if (c == l + 2) in_done = 1'b0;
            end
            $display("txn auto_start: L=%0d done after %0d edges", l, l + 1);
        end
    endtask

    task automatic test_zero_trigger();
        obs_t e, a;
        trigger = 1'b1;
        in_done = 1'b1;
        exp_q.push_back(mk(1'b1, 1'b1, 0));
        exp_q.push_back(mk(1'b0, 1'b0, 0));
        exp_q.push_back(mk(1'b1, 1'b1, 0));
        exp_q.push_back(mk(1'b1, 1'b1, 0));
        exp_q.push_back(mk(1'b0, 1'b0, 0));
        exp_q.push_back(mk(1'b0, 1'b0, 0));
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            a = '{done: done, busy: busy, rem: remaining};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL zero_trigger c%0d: got %b/%b/%0d want %b/%b/%0d", c, a.done, a.busy, a.rem, e.done, e.busy, e.rem);
            end
            case (c)
                0: trigger = 1'b0;
                1: begin in_done = 1'b0; trigger = 1'b1; end
                2: trigger = 1'b0;
                3: in_done = 1'b1;
                4: in_done = 1'b0;
                default: ;
            endcase
        end
        $display("txn zero_trigger: L=0 straight to DONE, ack on entry cycle honoured");
    endtask

    task automatic test_ignore_in_run();
        obs_t e, a;
        load = W'(16);
        trigger = 1'b1;
        push_run(16);
        exp_q.push_back(mk(1'b0, 1'b0, 0));
        exp_q.push_back(mk(1'b0, 1'b0, 0));
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            a = '{done: done, busy: busy, rem: remaining};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL ignore_in_run c%0d: got %b/%b/%0d want %b/%b/%0d", c, a.done, a.busy, a.rem, e.done, e.busy, e.rem);
            end
            case (c)
                0: begin load = '0; trigger = 1'b0; end
                8: begin load = W'(5); trigger = 1'b1; in_start = 1'b1; in_done = 1'b1; end
                9: begin load = '0; trigger = 1'b0; in_start = 1'b0; in_done = 1'b0; end
                17: in_done = 1'b1;
                18: in_done = 1'b0;
                default: ;
            endcase
        end
        $display("txn ignore_in_run: L=16 unaffected by mid-run requests");
    endtask

    task automatic test_back_to_back();
        obs_t e, a;
        int rems[13] = '{3, 2, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0};
        bit dns[13]  = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0};
        bit bsy[13]  = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0};
        load = W'(3);
        in_start = 1'b1;
        for (int c = 0; c < 13; c++) exp_q.push_back(mk(dns[c], bsy[c], rems[c]));
        for (int c = 0; c < 13; c++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            a = '{done: done, busy: busy, rem: remaining};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL back_to_back c%0d: got %b/%b/%0d want %b/%b/%0d", c, a.done, a.busy, a.rem, e.done, e.busy, e.rem);
            end
            case (c)
                0: begin in_start = 1'b0; load = '0; end
                4: load = W'(2);
                5: in_done = 1'b1;
                7: begin load = '0; in_done = 1'b0; end
                10: in_done = 1'b1;
                11: in_done = 1'b0;
                default: ;
            endcase
        end
        $display("txn back_to_back: L=3 then L=2 restarted right after ack");
    endtask

    task automatic test_reset_mid_run();
        obs_t e, a;
        load = W'(16);
        in_start = 1'b1;
        for (int k = 0; k <= 9; k++) exp_q.push_back(mk(1'b0, 1'b1, 16 - k));
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            a = '{done: done, busy: busy, rem: remaining};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL reset_mid_run c%0d: got %b/%b/%0d want %b/%b/%0d", c, a.done, a.busy, a.rem, e.done, e.busy, e.rem);
            end
            if (c == 0) begin load = '0; in_start = 1'b0; end
        end
        rst = 1'b1;
        for (int c = 0; c < 7; c++) exp_q.push_back(mk(1'b0, 1'b0, 0));
        #1;
        e = exp_q.pop_front();
        a = '{done: done, busy: busy, rem: remaining};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL reset_mid_run async: got %b/%b/%0d want %b/%b/%0d", a.done, a.busy, a.rem, e.done, e.busy, e.rem);
        end
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c == 0) rst = 1'b0;
            e = exp_q.pop_front();
            a = '{done: done, busy: busy, rem: remaining};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL reset_mid_run post c%0d: got %b/%b/%0d want %b/%b/%0d", c, a.done, a.busy, a.rem, e.done, e.busy, e.rem);
            end
        end
        $display("txn reset_mid_run: reset at remaining=7, no done afterwards");
    endtask

    initial begin
        test_reset();
        test_load_one();
        test_auto_start();
        test_zero_trigger();
        test_ignore_in_run();
        test_back_to_back();
        test_reset_mid_run();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d leftover entries want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
